// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
// Two-byte instruction fetch sequencer. Holds the program counter, reads one
// byte per handshake from a byte-wide memory and steers each byte into the
// low then high half of a downstream 16-bit instruction register. Done pulses
// for one cycle once both halves have been written.
module instruction_fetch_unit #(
    parameter int unsigned                ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0]      RESET_PC   = '0
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic                  PCLoad,
    input  logic [ADDR_WIDTH-1:0] PCIn,
    input  logic [7:0]            MemData,
    input  logic                  MemReady,
    output logic                  MemRead,
    output logic [ADDR_WIDTH-1:0] MemAddr,
    output logic [7:0]            IRData,
    output logic                  IRLH,
    output logic                  IRWrite,
    output logic [ADDR_WIDTH-1:0] PC,
    output logic                  Busy,
    output logic                  Done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] pc_inc;

    // Modulo-2^ADDR_WIDTH increment; wrap from all-ones to zero is silent.
    assign pc_inc = pc_q + ADDR_WIDTH'(1);

    // State and program counter registers with synchronous reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Next-state, PC update and all outputs, decoded from the current state
    // plus the memory handshake.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        MemRead = 1'b0;
        IRData  = '0;
        IRLH    = 1'b0;
        IRWrite = 1'b0;
        Busy    = 1'b0;
        Done    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // PCLoad is applied before the fetch starts, so a combined
                // Start+PCLoad fetches from the new target.
                if (PCLoad) begin
                    pc_d = PCIn;
                end
                if (Start) begin
                    state_d = S_LOW;
                end
            end
            S_LOW: begin
                MemRead = 1'b1;
                Busy    = 1'b1;
                IRData  = MemData;
                if (MemReady) begin
                    IRWrite = 1'b1;
                    pc_d    = pc_inc;
                    state_d = S_HIGH;
                end
            end
            S_HIGH: begin
                MemRead = 1'b1;
                Busy    = 1'b1;
                IRLH    = 1'b1;
                IRData  = MemData;
                if (MemReady) begin
                    IRWrite = 1'b1;
                    pc_d    = pc_inc;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // Start here is deliberately dropped; it must be re-asserted
                // once back in IDLE.
                Done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A reset edge must never write a partial byte or signal completion.
        if (Reset) begin
            IRWrite = 1'b0;
            MemRead = 1'b0;
            Done    = 1'b0;
        end
    end

    assign MemAddr = pc_q;
    assign PC      = pc_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Testbench for instruction_fetch_unit: directed scenarios followed by random
// stimulus, each cycle checked against a behavioural model of the fetch.
module tb_instruction_fetch_unit;

    localparam int unsigned AW     = 8;
    localparam logic [7:0]  RST_PC = 8'h00;

    logic       Clock = 1'b0;
    logic       Reset, Start, PCLoad, MemReady;
    logic [7:0] PCIn, MemData;
    logic       MemRead, IRLH, IRWrite, Busy, Done;
    logic [7:0] MemAddr, IRData, PC;

    always #5 Clock = ~Clock;

    instruction_fetch_unit #(.ADDR_WIDTH(AW), .RESET_PC(RST_PC)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .PCLoad(PCLoad),
        .PCIn(PCIn), .MemData(MemData), .MemReady(MemReady),
        .MemRead(MemRead), .MemAddr(MemAddr), .IRData(IRData), .IRLH(IRLH),
        .IRWrite(IRWrite), .PC(PC), .Busy(Busy), .Done(Done)
    );

    // Downstream 16-bit instruction register, loaded by the DUT strobes.
    logic [15:0] ir16 = 16'h0000;
    always @(posedge Clock) begin
        if (IRWrite === 1'b1) begin
            if (IRLH) ir16[15:8] <= IRData;
            else      ir16[7:0]  <= IRData;
        end
    end

    // Behavioural model: bytes fetched so far in the current instruction.
    logic [7:0]  mem [256];
    int          phase;       // 0 idle, 1 awaiting low byte, 2 awaiting high byte, 3 complete
    logic [7:0]  m_pc;
    logic [15:0] exp_instr;
    int          tests = 0;
    int          fails = 0;
    int          done_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic rst, input logic st, input logic pl,
                         input logic [7:0] pin, input logic rdy, input bit check);
        logic       fetching;
        logic [7:0] nxt;
        fetching = (phase == 1) || (phase == 2);
        Reset = rst; Start = st; PCLoad = pl; PCIn = pin; MemReady = rdy;
        MemData = fetching ? mem[m_pc] : 8'($urandom);
        #4;
        if (Done === 1'b1) done_seen++;
        if (check) begin
            chk("busy",    {31'd0, Busy},    {31'd0, fetching});
            chk("memread", {31'd0, MemRead}, {31'd0, fetching && !rst});
            chk("irwrite", {31'd0, IRWrite}, {31'd0, fetching && rdy && !rst});
            chk("irlh",    {31'd0, IRLH},    {31'd0, phase == 2});
            chk("done",    {31'd0, Done},    {31'd0, (phase == 3) && !rst});
            chk("irdata",  {24'd0, IRData},  {24'd0, fetching ? mem[m_pc] : 8'h00});
            chk("memaddr", {24'd0, MemAddr}, {24'd0, m_pc});
            chk("pc",      {24'd0, PC},      {24'd0, m_pc});
            if (phase == 3) chk("instr", {16'd0, ir16}, {16'd0, exp_instr});
        end
        @(posedge Clock);
        #1;
        if (rst) begin
            phase = 0;
            m_pc  = RST_PC;
        end else begin
            case (phase)
                0: begin
                    if (pl) m_pc = pin;
                    if (st) begin
                        phase     = 1;
                        nxt       = m_pc + 8'd1;
                        exp_instr = {mem[nxt], mem[m_pc]};
                    end
                end
                1, 2: if (rdy) begin
                    m_pc  = m_pc + 8'd1;
                    phase = phase + 1;
                end
                default: phase = 0;
            endcase
        end
    endtask

    initial begin
        int         d0;
        logic [8:0] waits;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        phase = 0; m_pc = RST_PC; exp_instr = 16'h0;
        Reset = 1'b1; Start = 1'b0; PCLoad = 1'b0; PCIn = 8'h00;
        MemReady = 1'b0; MemData = 8'h00;
        @(posedge Clock); #1;

        // Reset state
        cycle(1, 0, 0, 8'h00, 0, 0);
        cycle(1, 1, 1, 8'h55, 1, 1);
        cycle(1, 0, 0, 8'h00, 1, 1);

        // Best-case fetch from 0x10 with Start+PCLoad together
        mem[8'h10] = 8'h34; mem[8'h11] = 8'h12;
        cycle(0, 1, 1, 8'h10, 1, 1);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 8'h00, 1, 1);
        chk("pc_best", {24'd0, PC}, 32'h12);
        chk("ir_best", {16'd0, ir16}, 32'h1234);

        // Same fetch with 3 wait cycles in LOW and 2 in HIGH
        ir16 = 16'h0000;
        waits = 9'b011001000; // LSB first: 0,0,0,1,0,0,1,1,0
        cycle(0, 1, 1, 8'h10, 1, 1);
        for (int i = 0; i < 9; i++) cycle(0, 0, 0, 8'h00, waits[i], 1);
        chk("pc_wait", {24'd0, PC}, 32'h12);
        chk("ir_wait", {16'd0, ir16}, 32'h1234);

        // Wrap from 0xFF to 0x00 between bytes
        mem[8'hFF] = 8'hAB; mem[8'h00] = 8'hCD;
        cycle(0, 1, 1, 8'hFF, 1, 1);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 8'h00, 1, 1);
        chk("pc_wrap", {24'd0, PC}, 32'h01);
        chk("ir_wrap", {16'd0, ir16}, 32'hCDAB);

        // Start/PCLoad while busy and in DONE are ignored
        cycle(0, 1, 1, 8'h20, 1, 1);
        cycle(0, 1, 1, 8'h40, 0, 1);
        cycle(0, 1, 1, 8'h40, 1, 1);
        cycle(0, 1, 1, 8'h40, 0, 1);
        cycle(0, 1, 1, 8'h40, 1, 1);
        cycle(0, 1, 1, 8'h40, 1, 1);
        chk("pc_ignore", {24'd0, PC}, 32'h22);
        cycle(0, 1, 0, 8'h40, 1, 1);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 8'h00, 1, 1);
        chk("pc_next", {24'd0, PC}, 32'h24);
        chk("ir_next", {16'd0, ir16}, {16'd0, mem[8'h23], mem[8'h22]});

        // Reset on the cycle the high byte is ready
        d0 = done_seen;
        cycle(0, 1, 1, 8'h30, 1, 1);
        cycle(0, 0, 0, 8'h00, 1, 1);
        cycle(1, 0, 0, 8'h00, 1, 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 8'h00, 1, 1);
        chk("pc_reset", {24'd0, PC}, {24'd0, RST_PC});
        chk("done_after_reset", done_seen - d0, 0);

        // Start held high: one instruction per 4 cycles
        d0 = done_seen;
        for (int i = 0; i < 12; i++) cycle(0, 1, 0, 8'h00, 1, 1);
        chk("held_dones", done_seen - d0, 3);
        chk("held_pc", {24'd0, PC}, {24'd0, RST_PC + 8'd6});

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 49) == 0), 1'($urandom), ($urandom_range(0, 3) == 0),
                  8'($urandom), ($urandom_range(0, 2) != 0), 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Two-byte instruction fetch sequencer that sits directly upstream of the 16-bit instruction register. It holds the program counter, reads the instruction one byte at a time from a byte-wide memory with a ready handshake, and drives the register's 8-bit data bus, half-select and write enable so the low byte is loaded first and the high byte second. It pulses a done flag once the full 16-bit instruction is in the register.

## Interface
- ADDR_WIDTH, 8, program counter and memory address width
- RESET_PC, 0, program counter value after reset
- Clock  input  1  system clock, all state updates on rising edge
- Reset  input  1  synchronous, active-high; forces idle state and PC = RESET_PC
- Start  input  1  fetch request, sampled only in IDLE
- PCLoad  input  1  load PC from PCIn, honoured only in IDLE
- PCIn  input  ADDR_WIDTH  jump/branch target
- MemData  input  8  byte returned by memory for MemAddr
- MemReady  input  1  MemData valid this cycle
- MemRead  output  1  memory read request
- MemAddr  output  ADDR_WIDTH  memory address, equals PC
- IRData  output  8  byte to instruction register
- IRLH  output  1  0 = low half, 1 = high half
- IRWrite  output  1  instruction register write enable
- PC  output  ADDR_WIDTH  current program counter
- Busy  output  1  fetch in progress (LOW or HIGH state)
- Done  output  1  one-cycle pulse, full instruction written

## Operation
- States: IDLE, LOW, HIGH, DONE. Reset state IDLE.
- IDLE: all request/strobe outputs 0. PCLoad=1 -> PC <= PCIn. Start=1 -> go LOW.
- Start and PCLoad together in IDLE: PC takes PCIn and the fetch begins at PCIn.
- LOW: MemRead=1, MemAddr=PC, IRLH=0. While MemReady=0, stay in LOW, IRWrite=0. When MemReady=1: IRWrite=1, IRData=MemData (combinational pass-through), PC <= PC+1, go HIGH.
- HIGH: as LOW with IRLH=1; on MemReady=1 write high byte, PC <= PC+1, go DONE.
- DONE: Done=1, MemRead=0, IRWrite=0; unconditionally return to IDLE next edge. Start in DONE is ignored (must be re-asserted in IDLE).
- PC increment is modulo 2^ADDR_WIDTH: PC = 2^ADDR_WIDTH-1 wraps to 0 between bytes with no error flag.
- PCLoad and Start outside IDLE are ignored and not queued.
- IRData = MemData whenever in LOW/HIGH; 0 otherwise.
- Busy = 1 in LOW and HIGH only.

## Timing
- All outputs are functions of the state register plus MemReady/MemData; no registered delay on IRWrite, so the register captures the byte on the same edge the FSM leaves LOW/HIGH.
- Reset values: state IDLE, PC = RESET_PC, MemRead=0, IRWrite=0, IRLH=0, IRData=0, Busy=0, Done=0.
- Reset has priority over every input. While Reset=1, IRWrite, MemRead and Done are forced 0 combinationally, so a reset asserted mid-fetch never writes a partial byte on that edge.
- Reset mid-fetch abandons the fetch; a low byte already written remains in the instruction register (this block does not clear it).
- Best-case latency (MemReady held 1): Start sampled at edge 0; LOW during cycle 1 (low byte written at edge 1); HIGH during cycle 2 (edge 2); Done high during cycle 3; IDLE at cycle 4. Each memory wait cycle adds one cycle.
- Back-to-back fetches: minimum 4 cycles per instruction.

## Test plan
- Reset, memory {0x10:0x34, 0x11:0x12}, PCLoad=1 PCIn=0x10 with Start=1, MemReady=1 -> IRWrite high two consecutive cycles (IRLH 0 then 1, IRData 0x34 then 0x12), Done one cycle later, PC=0x12, register holds 0x1234.
- Same fetch with MemReady low 3 cycles in LOW and 2 in HIGH -> IRWrite only on ready cycles, Done 5 cycles later than best case, MemAddr stable during waits.
- PC=0xFF, Start -> low byte from 0xFF, high byte from 0x00, final PC=0x01.
- Start and PCLoad (PCIn=0x40) pulsed while Busy -> ignored; PC and fetch sequence unaffected; next Start in IDLE fetches from incremented PC.
- Reset asserted in cycle the HIGH byte is ready -> IRWrite stays 0 that cycle, state IDLE, PC=RESET_PC, Done never pulses.
- Start held high continuously -> fetches repeat every 4 cycles with one Done pulse each, PC advancing by 2 per instruction.
